dot_product_seq: RTL and testbench
==================================

Name: dot_product_seq

Overview:
Sequential, handshaked version of the combinational dot-product datapath. It accepts a packed vector pair on a valid/ready input and computes the sum of products with one multiply-accumulate per clock. The sum is held on a valid/ready output until the consumer takes it. It is intended for wide SIZE values, where a fully parallel multiplier tree is too costly.

Parameters:
SIZE, 4, number of elements per vector (>=1)
DW, 8, element width in bits, unsigned
RW, 16, result/accumulator width in bits (RW >= 2*DW not required)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  a/b presented
in_ready  output  1  block can accept a/b
a  input  DW*SIZE  packed vector A; element i = a[i*DW +: DW], element 0 at LSBs
b  input  DW*SIZE  packed vector B, same packing
out_valid  output  1  result valid
out_ready  input  1  consumer takes result
result  output  RW  dot product
busy  output  1  high in RUN or DONE

Behaviour:
- Reset values (asynchronous, on rst high): state=IDLE, in_ready=1, out_valid=0, result=0, busy=0. Accumulator, index and operand registers are cleared.
- Three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture a and b into internal registers, set acc=0 and idx=0, go to RUN.
  - a/b are sampled only on the accept edge; later input changes are ignored.
- RUN:
  - in_ready=0.
  - Each cycle: acc <= acc + zext(a_r[idx]*b_r[idx]). The product is full 2*DW bits, then zero-extended or truncated to RW.
  - Addition wraps modulo 2^RW (default build).
  - idx increments each cycle. When idx==SIZE-1, the final sum is written to result and the FSM goes to DONE.
- DONE:
  - out_valid=1 and result is stable.
  - On out_ready, go to IDLE with out_valid=0 on the next edge.
  - in_ready stays 0 in DONE, so a new vector is accepted no earlier than the cycle after the result is taken.
- Latency: accept at edge N gives out_valid high after edge N+SIZE.
  - Minimum throughput: one vector per SIZE+2 cycles with out_ready tied high.
- result holds its last value in IDLE and updates only on the RUN->DONE transition.
- SIZE=1: a single RUN cycle, then DONE.
- in_valid while not in_ready: ignored, no capture, no error.
- rst asserted mid-RUN or in DONE: immediate return to reset values. The partial sum is discarded and no out_valid pulse is produced.
- out_ready in IDLE/RUN: ignored.

Optional Feature:
DOTP_SATURATE_EN
- Defined: the accumulator saturates at 2^RW-1. Any add whose true sum exceeds the maximum clamps acc to 2^RW-1, and acc stays clamped for the rest of the vector. Ports and timing are unchanged.
- Undefined: modulo-2^RW wrap as described in Behaviour.

Test Plan:
- Basic: a={4,3,2,1}, b={8,7,6,5}, out_ready=1 -> out_valid exactly 4 cycles after accept, result=70, busy high over those cycles.
- Backpressure: same vectors, out_ready=0 for 10 cycles -> out_valid/result=70 held stable, in_ready=0 throughout. Then out_ready=1 for one cycle -> out_valid drops, in_ready=1.
- Overflow: all elements 255 (SIZE=4) -> result=63492 (260100 mod 65536). With DOTP_SATURATE_EN -> result=65535.
- Input isolation: accept {1,1,1,1}·{2,2,2,2}, then change a/b and pulse in_valid during RUN -> result=8, second request not accepted until IDLE.
- Reset mid-op: assert rst 2 cycles after accept -> outputs at reset values immediately, no out_valid. A subsequent {4,3,2,1}·{8,7,6,5} gives 70.
- Back-to-back with SIZE=1 build: a=7, b=9 then a=255, b=2 -> results 63 and 510, each out_valid one cycle after its accept.

Source files
------------

// File: rtl/dot_product_seq_if.sv
// -----------------------------------------------------------------------------
// dot_product_seq_if
//
// Purpose : bundles the operand-side and result-side valid/ready handshakes of
//           dot_product_seq into one interface.
//
// Signals :
//   in_valid  - producer presents a/b
//   in_ready  - block can accept a/b
//   a, b      - packed operand vectors, element i at [i*DW +: DW]
//   out_valid - result valid
//   out_ready - consumer takes result
//   result    - dot product, RW bits
//   busy      - block is computing or holding a result
//
// Modports:
//   master - producer/consumer side (drives operands, takes results)
//   slave  - the dot-product engine
// -----------------------------------------------------------------------------
interface dot_product_seq_if #(
  parameter int SIZE = 4,
  parameter int DW   = 8,
  parameter int RW   = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DW*SIZE-1:0]   a;
  logic [DW*SIZE-1:0]   b;
  logic                 out_valid;
  logic                 out_ready;
  logic [RW-1:0]        result;
  logic                 busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/dot_product_seq.sv
// -----------------------------------------------------------------------------
// dot_product_seq
//
// Purpose : sequential dot product of two packed unsigned vectors, one
//           multiply-accumulate per clock. Operands are captured on the input
//           handshake, the sum is held on the output handshake until taken.
//
// Ports   :
//   clk  - system clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - dot_product_seq_if.slave
//            in_valid/in_ready/a/b       : operand handshake
//            out_valid/out_ready/result  : result handshake
//            busy                        : high while computing or holding
//
// Build option:
//   DOTP_SATURATE_EN - when defined, the accumulator clamps at 2^RW-1 instead
//                      of wrapping modulo 2^RW. Ports and timing unchanged.
//
// Timing  : accept at edge N -> out_valid high after edge N+SIZE. With
//           out_ready tied high a new vector can be taken every SIZE+2 cycles.
// -----------------------------------------------------------------------------
module dot_product_seq #(
  parameter int SIZE = 4,
  parameter int DW   = 8,
  parameter int RW   = 16
) (
  input  logic               clk,
  input  logic               rst,
  dot_product_seq_if.slave   bus
);

  // Index needs at least one bit even for SIZE=1.
  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------

  // Full-width product is zero-extended or truncated to the accumulator width.
  function automatic logic [RW-1:0] prod_to_acc(input logic [2*DW-1:0] p);
    return RW'(p);
  endfunction

  // Accumulator update: wraps modulo 2^RW, or clamps at all-ones when the
  // saturating build is selected. Products are unsigned, so once clamped the
  // accumulator can only be re-clamped and stays at the maximum.
  function automatic logic [RW-1:0] acc_add(input logic [RW-1:0] acc,
                                            input logic [RW-1:0] p);
`ifdef DOTP_SATURATE_EN
    logic [RW:0] s;
    s = {1'b0, acc} + {1'b0, p};
    return s[RW] ? {RW{1'b1}} : s[RW-1:0];
`else
    return acc + p;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t               state_q,     state_d;
  logic [IW-1:0]        idx_q,       idx_d;
  logic [RW-1:0]        acc_q,       acc_d;
  logic [DW*SIZE-1:0]   a_q,         a_d;
  logic [DW*SIZE-1:0]   b_q,         b_d;
  logic [RW-1:0]        result_q,    result_d;
  logic                 in_ready_q,  in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q,      busy_d;

  // ---------------------------------------------------------------------------
  // Element select and multiply-accumulate
  // ---------------------------------------------------------------------------
  logic [DW-1:0]        op_a;
  logic [DW-1:0]        op_b;
  logic [2*DW-1:0]      prod;
  logic [RW-1:0]        acc_sum;

  // Explicit mux over elements keeps the select free of variable part-selects.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (idx_q == IW'(i)) begin
        op_a = a_q[i*DW +: DW];
        op_b = b_q[i*DW +: DW];
      end
    end
  end

  always_comb begin
    prod    = {{DW{1'b0}}, op_a} * {{DW{1'b0}}, op_b};
    acc_sum = acc_add(acc_q, prod_to_acc(prod));
  end

  // ---------------------------------------------------------------------------
  // Control: next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    unique case (state_q)
      S_IDLE: begin
        // Operands are sampled only here; later input changes are ignored.
        if (bus.in_valid && in_ready_q) begin
          a_d        = bus.a;
          b_d        = bus.b;
          acc_d      = '0;
          idx_d      = '0;
          state_d    = S_RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      S_RUN: begin
        acc_d = acc_sum;
        if (idx_q == LAST_IDX) begin
          // result only ever changes on this transition.
          result_d    = acc_sum;
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      S_DONE: begin
        // in_ready stays low here, so the next accept is at least one cycle
        // after the result is taken.
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // All outputs come straight from flops.
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_dot_product_seq.sv
module tb_dot_product_seq;

  localparam int SIZE = 4;
  localparam int DW   = 8;
  localparam int RW   = 16;
  localparam int W    = DW * SIZE;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dot_product_seq_if #(.SIZE(SIZE), .DW(DW), .RW(RW)) ifc ();
  dot_product_seq_if #(.SIZE(1),    .DW(DW), .RW(RW)) ifc1 ();

  dot_product_seq #(.SIZE(SIZE), .DW(DW), .RW(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  dot_product_seq #(.SIZE(1), .DW(DW), .RW(RW)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (ifc1.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: sum of element products, each product reduced to RW bits, then
  // either wrapped modulo 2^RW or clamped at the maximum.
  function automatic logic [RW-1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
    longint sum;
    longint modv;
    sum  = 0;
    modv = longint'(1) << RW;
    for (int i = 0; i < SIZE; i++)
      sum += (longint'(av[i*DW +: DW]) * longint'(bv[i*DW +: DW])) % modv;
`ifdef DOTP_SATURATE_EN
    if (sum > modv - 1) sum = modv - 1;
`else
    sum = sum % modv;
`endif
    return RW'(sum);
  endfunction

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [RW-1:0] exp;
    string         nm;
  } vec_t;

  vec_t tbl[6];

  // Waits for in_ready, then presents a/b for exactly one accept edge and
  // scrambles the inputs afterwards.
  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv);
    int n;
    n = 0;
    @(negedge clk);
    while (!ifc.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 64'(ifc.in_ready), 64'd1);
    ifc.a        = av;
    ifc.b        = bv;
    ifc.in_valid = 1'b1;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    ifc.a        = W'($urandom);
    ifc.b        = W'($urandom);
  endtask

  // Counts edges from the accept edge until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!ifc.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_txn(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [RW-1:0] expv, input string nm);
    int lat;
    ifc.out_ready = 1'b1;
    accept(av, bv);
    check({"busy_run_", nm}, 64'(ifc.busy), 64'd1);
    wait_valid(lat);
    check({"latency_", nm}, 64'(lat), 64'(SIZE));
    check({"result_", nm}, 64'(ifc.result), 64'(expv));
    check({"busy_done_", nm}, 64'(ifc.busy), 64'd1);
    @(posedge clk);
    #1;
    check({"ov_drop_", nm}, 64'(ifc.out_valid), 64'd0);
    check({"ir_back_", nm}, 64'(ifc.in_ready), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [W-1:0] ra, rb;

    tbl[0] = '{a: {8'd4, 8'd3, 8'd2, 8'd1}, b: {8'd8, 8'd7, 8'd6, 8'd5}, exp: 16'd70, nm: "basic"};
`ifdef DOTP_SATURATE_EN
    tbl[1] = '{a: {4{8'd255}}, b: {4{8'd255}}, exp: 16'd65535, nm: "overflow"};
    tbl[5] = '{a: {8'd200, 8'd200, 8'd0, 8'd0}, b: {8'd200, 8'd200, 8'd0, 8'd0}, exp: 16'd65535, nm: "ovf2"};
`else
    tbl[1] = '{a: {4{8'd255}}, b: {4{8'd255}}, exp: 16'd63492, nm: "overflow"};
    tbl[5] = '{a: {8'd200, 8'd200, 8'd0, 8'd0}, b: {8'd200, 8'd200, 8'd0, 8'd0}, exp: 16'd14464, nm: "ovf2"};
`endif
    tbl[2] = '{a: '0, b: {4{8'd255}}, exp: 16'd0, nm: "zero"};
    tbl[3] = '{a: {8'd0, 8'd0, 8'd0, 8'd255}, b: {8'd0, 8'd0, 8'd0, 8'd255}, exp: 16'd65025, nm: "single"};
    tbl[4] = '{a: {8'd1, 8'd2, 8'd3, 8'd4}, b: {4{8'd1}}, exp: 16'd10, nm: "ones"};

    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    ifc.a         = '0;
    ifc.b         = '0;
    ifc1.in_valid  = 1'b0;
    ifc1.out_ready = 1'b0;
    ifc1.a         = '0;
    ifc1.b         = '0;

    // Reset state
    rst = 1'b1;
    #12;
    check("rst_in_ready", 64'(ifc.in_ready), 64'd1);
    check("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    check("rst_result", 64'(ifc.result), 64'd0);
    check("rst_busy", 64'(ifc.busy), 64'd0);
    check("rst1_in_ready", 64'(ifc1.in_ready), 64'd1);
    check("rst1_out_valid", 64'(ifc1.out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors
    for (int i = 0; i < 6; i++)
      do_txn(tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].nm);

    // Backpressure: result held while out_ready low
    ifc.out_ready = 1'b0;
    accept({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
    wait_valid(lat);
    check("bp_latency", 64'(lat), 64'(SIZE));
    for (int k = 0; k < 10; k++) begin
      check("bp_out_valid", 64'(ifc.out_valid), 64'd1);
      check("bp_result", 64'(ifc.result), 64'd70);
      check("bp_in_ready", 64'(ifc.in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b0;
    check("bp_ov_drop", 64'(ifc.out_valid), 64'd0);
    check("bp_ir_back", 64'(ifc.in_ready), 64'd1);
    check("bp_result_hold", 64'(ifc.result), 64'd70);

    // Input isolation: inputs change and in_valid pulses during RUN
    ifc.out_ready = 1'b0;
    accept({4{8'd1}}, {4{8'd2}});
    ifc.a        = {4{8'd200}};
    ifc.b        = {4{8'd100}};
    ifc.in_valid = 1'b1;
    check("iso_in_ready_run", 64'(ifc.in_ready), 64'd0);
    wait_valid(lat);
    check("iso_result", 64'(ifc.result), 64'd8);
    check("iso_in_ready_done", 64'(ifc.in_ready), 64'd0);
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("iso_idle_ready", 64'(ifc.in_ready), 64'd1);
    check("iso_no_accept", 64'(ifc.busy), 64'd0);

    // Reset mid-operation
    ifc.out_ready = 1'b1;
    accept({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(ifc.in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(ifc.out_valid), 64'd0);
    check("mid_rst_busy", 64'(ifc.busy), 64'd0);
    check("mid_rst_result", 64'(ifc.result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < SIZE + 2; k++) begin
      @(posedge clk);
      #1;
      check("mid_rst_no_ov", 64'(ifc.out_valid), 64'd0);
    end
    do_txn({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 16'd70, "after_rst");

    // Randomized vectors against the reference
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 5 == 0) ra = ra | {SIZE{8'hF0}};
      do_txn(ra, rb, model(ra, rb), "rand");
    end

    // SIZE=1 instance, back-to-back
    @(negedge clk);
    ifc1.out_ready = 1'b1;
    ifc1.a         = 8'd7;
    ifc1.b         = 8'd9;
    ifc1.in_valid  = 1'b1;
    check("s1_ready_a", 64'(ifc1.in_ready), 64'd1);
    @(posedge clk);
    #1;
    ifc1.in_valid = 1'b0;
    check("s1_run_no_ov", 64'(ifc1.out_valid), 64'd0);
    check("s1_busy", 64'(ifc1.busy), 64'd1);
    @(posedge clk);
    #1;
    check("s1_ov_a", 64'(ifc1.out_valid), 64'd1);
    check("s1_result_a", 64'(ifc1.result), 64'd63);
    @(posedge clk);
    #1;
    check("s1_idle_ready", 64'(ifc1.in_ready), 64'd1);
    check("s1_idle_ov", 64'(ifc1.out_valid), 64'd0);
    ifc1.a        = 8'd255;
    ifc1.b        = 8'd2;
    ifc1.in_valid = 1'b1;
    @(posedge clk);
    #1;
    ifc1.in_valid = 1'b0;
    check("s1_run_no_ov_b", 64'(ifc1.out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("s1_ov_b", 64'(ifc1.out_valid), 64'd1);
    check("s1_result_b", 64'(ifc1.result), 64'd510);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
